ov7670_roi_zoom: RTL
====================

# ov7670_roi_zoom

Downstream pixel-stream stage that sits between the OV7670 capture controller and the 320x240 RGB444 frame buffer, in the `pclk` domain. It watches the capture controller's write stream (`we`/`wData`, one pixel per two `pclk` during `href`) and tracks pixel position with its own counters. It selects a 160x120 region of interest and writes it, upscaled 2x by nearest-neighbour, as a full 320x240 image into the frame buffer. A 160-entry line buffer supplies the vertical duplicate row.

## Interface
- `ROI_W`, 160: ROI width in source pixels. Fixed; output width is 2*ROI_W = 320.
- `ROI_H`, 120: ROI height in source lines. Fixed; output height is 240.
- `pclk  in  1`: camera pixel clock; all logic is on its rising edge.
- `reset  in  1`: asynchronous, active-high.
- `v_sync  in  1`: camera vsync. High means frame blanking.
- `in_we  in  1`: source pixel strobe from the capture controller.
- `in_data  in  12`: source pixel, RGB444.
- `roi_x  in  9`: ROI origin column. Clamped to 160.
- `roi_y  in  8`: ROI origin row. Clamped to 120.
- `out_we  out  1`: frame-buffer write enable.
- `out_addr  out  17`: frame-buffer address, computed as row*320 + col.
- `out_data  out  12`: frame-buffer write data.
- `frame_done  out  1`: one-cycle pulse after the last write of a frame.
- `overrun  out  1`: sticky error flag. Cleared only by reset.

## Operation
- **Source position counters.**
  - `sx` counts 0..319 and `sy` counts 0..239.
  - Each `in_we` advances `sx`. When `sx` wraps from 319 to 0, `sy` increments.
  - While `v_sync` is high, both counters hold 0.
- **ROI latch.** While `v_sync` is high, `roi_x` and `roi_y` are latched, after clamping. They are stable for the whole frame.
- **ROI pixel.** An `in_we` is an ROI pixel when `rx = sx - roi_x` is in 0..159 and `ry = sy - roi_y` is in 0..119.
- **Row base.** `row_base` starts at 0 each frame and increases by 640 per completed ROI row. No multiplier is used.
- **State machine.** States are IDLE, LIVE, REPLAY and DONE.
  - IDLE: `out_we` is 0. On `v_sync` going 1 to 0, go to LIVE.
  - LIVE, first copy: an ROI pixel writes `row_base + 2*rx` in the next cycle.
  - LIVE, second copy: `row_base + 2*rx + 1` is written in the cycle after that, with the same data.
  - LIVE, line buffer: the pixel is stored in `linebuf[rx]`.
  - LIVE to REPLAY: after the second copy of the pixel with `rx = 159`.
  - REPLAY: read `linebuf[i]` for i = 0..159 (synchronous read, 1-cycle latency).
  - REPLAY writes: for each `i`, write `row_base + 320 + 2*i`, then `+1`. This is 320 consecutive `out_we` cycles.
  - REPLAY exit: after the last write, `row_base += 640`. If `ry` was 119, go to DONE; otherwise go to LIVE.
  - DONE: pulse `frame_done` for one cycle on entry. Ignore `in_we` until `v_sync` rises.
  - From any state, `v_sync` high goes to IDLE. This clears the pending duplicate and `row_base`, and aborts any REPLAY in progress.
- **Overrun.** `overrun` is set, and the offending pixel is dropped (no write, no line-buffer store), when either:
  - an ROI pixel arrives during REPLAY;
  - an ROI pixel arrives while its predecessor's second copy is still pending, i.e. `in_we` on consecutive cycles.
- **Non-ROI pixels.** They only advance the counters. They never write.
- **Arithmetic.** Address arithmetic is 17 bits unsigned. The maximum address is 76799. `rx` and `ry` are compared as signed or with borrow, so pixels left of or above the ROI are rejected.

## Timing
- **Reset values.** `out_we` = 0, `out_addr` = 0, `out_data` = 0, `frame_done` = 0, `overrun` = 0. State is IDLE; `sx`, `sy` and `row_base` are 0.
- **Latency.** `in_we` at cycle t produces a write at t+1 (even column) and t+2 (odd column). All outputs are registered.
- **Replay start.** The first REPLAY write occurs 2 cycles after the last LIVE write: one cycle for the state change and one for the line-buffer read.
- **Row budget.** An OV7670 line is at least 1568 `pclk`. A ROI row uses 320 cycles in LIVE plus 322 in REPLAY, so no overrun occurs with compliant input.
- **Reset mid-operation.** Reset returns the block to IDLE immediately. The first frame is processed only after the next `v_sync` low edge.

## Test plan
- **Origin ROI.** Stimulus: `roi_x` = 0, `roi_y` = 0, source pixel value equals `(sy<<6)|sx[5:0]`, one `in_we` per 2 cycles. Required:
  - source (0,0) writes addresses 0, 1, 320 and 321;
  - source (159,119) writes 76478, 76479, 76798 and 76799;
  - exactly 76800 writes per frame;
  - one `frame_done` pulse.
- **Offset ROI.** Stimulus: `roi_x` = 100, `roi_y` = 50. Required:
  - source (99,50) and (100,49) produce no write;
  - source (100,50) writes address 0;
  - source (101,50) writes address 2.
- **Clamp.** Stimulus: `roi_x` = 300, `roi_y` = 200. Required: behaves as 160/120, and source (160,120) writes address 0.
- **Overrun.** Stimulus: `in_we` on two consecutive cycles inside the ROI. Required: `overrun` = 1, the second pixel is not written, and the flag persists across `v_sync`.
- **Vsync mid-replay.** Stimulus: raise `v_sync` during REPLAY of row 10. Required: `out_we` is 0 from the next cycle. The next frame restarts at address 0, with no `frame_done` for the aborted frame.
- **Reset mid-frame.** Stimulus: assert `reset` during LIVE. Required: all outputs 0 immediately, and the state stays IDLE until a `v_sync` low edge.

Source files
------------

// File: rtl/ov7670_roi_zoom.sv
`timescale 1ns/1ps
// Region-of-interest 2x nearest-neighbour zoom between the OV7670 capture stream and a 320x240 frame buffer.
// Each ROI pixel is written twice on its live row, then the buffered row is replayed as the duplicate line.
module ov7670_roi_zoom #(
  parameter int ROI_W = 160,
  parameter int ROI_H = 120
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        v_sync,
  input  logic        in_we,
  input  logic [11:0] in_data,
  input  logic [8:0]  roi_x,
  input  logic [7:0]  roi_y,
  output logic        out_we,
  output logic [16:0] out_addr,
  output logic [11:0] out_data,
  output logic        frame_done,
  output logic        overrun
);

  localparam logic [8:0]  ROI_W9   = 9'(ROI_W);
  localparam logic [7:0]  ROI_H8   = 8'(ROI_H);
  localparam logic [7:0]  RX_LAST  = 8'(ROI_W - 1);
  localparam logic [7:0]  RY_LAST  = 8'(ROI_H - 1);
  localparam logic [8:0]  REP_LAST = 9'(2 * ROI_W);
  localparam logic [16:0] OUT_W    = 17'(2 * ROI_W);
  localparam logic [16:0] ROW_STEP = 17'(4 * ROI_W);
  localparam logic [8:0]  SX_LAST  = 9'd319;
  localparam logic [7:0]  SY_LAST  = 8'd239;

  // IDLE: blanking | LIVE: ROI row in flight | REPLAY: duplicate row from line buffer | DONE: frame finished
  typedef enum logic [1:0] {IDLE, LIVE, REPLAY, DONE} state_t;
  state_t state, state_nxt;

  logic        v_sync_q;
  logic [8:0]  sx;
  logic [7:0]  sy;
  logic [8:0]  roi_x_q;
  logic [7:0]  roi_y_q;
  logic [16:0] row_base;
  logic        pend, pend_last, last_row, done_flag;
  logic [8:0]  rep_cnt;
  logic [7:0]  rd_idx;
  logic [11:0] lb_q;
  logic [11:0] linebuf [ROI_W];

  logic [9:0]  rx_full;
  logic [8:0]  ry_full;
  logic [7:0]  rx, ry;
  logic        in_roi, roi_pix, accept, drop;

  // Borrow bit of the subtraction rejects pixels left of / above the ROI.
  assign rx_full = {1'b0, sx} - {1'b0, roi_x_q};
  assign ry_full = {1'b0, sy} - {1'b0, roi_y_q};
  assign rx      = rx_full[7:0];
  assign ry      = ry_full[7:0];
  assign in_roi  = !rx_full[9] && (rx_full[8:0] < ROI_W9) && !ry_full[8] && (ry < ROI_H8);
  assign roi_pix = in_we && in_roi && !v_sync;
  assign accept  = roi_pix && (state == LIVE) && !pend;
  assign drop    = roi_pix && ((state == REPLAY) || ((state == LIVE) && pend));
  assign rd_idx  = rep_cnt[8:1];

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      sx      <= '0;
      sy      <= '0;
      roi_x_q <= '0;
      roi_y_q <= '0;
    end else if (v_sync) begin
      sx      <= '0;
      sy      <= '0;
      roi_x_q <= (roi_x > ROI_W9) ? ROI_W9 : roi_x;
      roi_y_q <= (roi_y > ROI_H8) ? ROI_H8 : roi_y;
    end else if (in_we) begin
      if (sx == SX_LAST) begin
        sx <= '0;
        sy <= (sy == SY_LAST) ? 8'd0 : sy + 8'd1;
      end else begin
        sx <= sx + 9'd1;
      end
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (v_sync_q && !v_sync) state_nxt = LIVE;
      LIVE:    if (pend && pend_last) state_nxt = REPLAY;
      REPLAY:  if (rep_cnt == REP_LAST) state_nxt = last_row ? DONE : LIVE;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (v_sync) state_nxt = IDLE;
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      v_sync_q   <= 1'b0;
      out_we     <= 1'b0;
      out_addr   <= '0;
      out_data   <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      row_base   <= '0;
      pend       <= 1'b0;
      pend_last  <= 1'b0;
      last_row   <= 1'b0;
      done_flag  <= 1'b0;
      rep_cnt    <= '0;
    end else begin
      out_we     <= 1'b0;
      frame_done <= 1'b0;
      v_sync_q   <= v_sync;
      if (drop) overrun <= 1'b1;
      if (v_sync) begin
        row_base  <= '0;
        pend      <= 1'b0;
        pend_last <= 1'b0;
        done_flag <= 1'b0;
        rep_cnt   <= '0;
      end else begin
        case (state)
          LIVE: begin
            if (pend) begin
              // Second copy reuses the data still held on out_data.
              out_we    <= 1'b1;
              out_addr  <= out_addr + 17'd1;
              pend      <= 1'b0;
              pend_last <= 1'b0;
            end else if (accept) begin
              out_we    <= 1'b1;
              out_addr  <= row_base + {8'd0, rx, 1'b0};
              out_data  <= in_data;
              pend      <= 1'b1;
              pend_last <= (rx == RX_LAST);
              if (rx == RX_LAST) last_row <= (ry == RY_LAST);
            end
          end
          REPLAY: begin
            rep_cnt <= rep_cnt + 9'd1;
            if (rep_cnt != 9'd0) begin
              out_we   <= 1'b1;
              out_addr <= row_base + OUT_W + {8'd0, rep_cnt - 9'd1};
              out_data <= lb_q;
            end
            if (rep_cnt == REP_LAST) begin
              rep_cnt  <= '0;
              row_base <= row_base + ROW_STEP;
            end
          end
          DONE: begin
            if (!done_flag) begin
              frame_done <= 1'b1;
              done_flag  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Replay reads one entry per two cycles; each entry feeds both copies.
  always_ff @(posedge pclk) begin
    if (accept) linebuf[rx] <= in_data;
    if (rd_idx < ROI_W9[7:0]) lb_q <= linebuf[rd_idx];
  end

endmodule
